// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the memory domain and, after a gap, the core domain. Lock loss in
// the released states restarts the whole sequence and is counted.
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_GAP_CYCLES    = 64
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       mem_resetn,
  output logic       core_resetn,
  output logic       ready,
  output logic [7:0] relock_count
);

  // Counter only ever reaches (parameter - 1), so $clog2 of the largest one is enough.
  localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MAX_CD = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                   LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

  localparam logic [2:0] ST_PLL_RESET   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
  localparam logic [2:0] ST_STABLE      = 3'd2;
  localparam logic [2:0] ST_RELEASE_MEM = 3'd3;
  localparam logic [2:0] ST_RUN         = 3'd4;

  logic             r_sync1;
  logic             r_sync2;
  logic             w_locked_s;
  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_relock_inc;
  logic             r_pll_rst;
  logic             r_mem_resetn;
  logic             r_core_resetn;
  logic             r_ready;
  logic [7:0]       r_relock_count;

  assign w_locked_s = r_sync2;

  // Two-flop synchronizer: the only place pll_locked is sampled.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, shared counter and lock-loss event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_relock_inc = 1'b0;
    case (r_state)
      ST_PLL_RESET: begin
        // relock_req deliberately ignored here so the pulse is never stretched.
        if (r_cnt == PLL_RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
        end else if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
        end
      end
      ST_STABLE: begin
        if (relock_req) begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
        end else if (!w_locked_s) begin
          // A glitch only restarts the lock wait; the PLL is not re-reset.
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_RELEASE_MEM;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_MEM: begin
        if (!w_locked_s) begin
          w_state_nxt  = ST_PLL_RESET;
          w_cnt_nxt    = '0;
          w_relock_inc = 1'b1;
        end else if (relock_req) begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt;
        // Lock loss wins over relock_req so a coincident pair still counts once.
        if (!w_locked_s) begin
          w_state_nxt  = ST_PLL_RESET;
          w_cnt_nxt    = '0;
          w_relock_inc = 1'b1;
        end else if (relock_req) begin
          w_state_nxt = ST_PLL_RESET;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PLL_RESET;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst     <= 1'b1;
      r_mem_resetn  <= 1'b0;
      r_core_resetn <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_pll_rst     <= (w_state_nxt == ST_PLL_RESET);
      r_mem_resetn  <= (w_state_nxt == ST_RELEASE_MEM) || (w_state_nxt == ST_RUN);
      r_core_resetn <= (w_state_nxt == ST_RUN);
      r_ready       <= (w_state_nxt == ST_RUN);
    end
  end

  // Saturating lock-loss counter, cleared only by rst_n.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_relock_count <= 8'd0;
    end else if (w_relock_inc && (r_relock_count != 8'hFF)) begin
      r_relock_count <= r_relock_count + 8'd1;
    end
  end

  assign pll_rst      = r_pll_rst;
  assign mem_resetn   = r_mem_resetn;
  assign core_resetn  = r_core_resetn;
  assign ready        = r_ready;
  assign relock_count = r_relock_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with 4/32/8/4 parameters. Each scenario pushes
// its expected per-cycle timeline to a queue, then pops one entry per sample.
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       mem_resetn;
  logic       core_resetn;
  logic       ready;
  logic [7:0] relock_count;
  logic [3:0] w_outs;

  typedef struct packed {
    logic [3:0] outs;  // {pll_rst, mem_resetn, core_resetn, ready}
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp;
  int   n_bad;

  localparam logic [3:0] O_PLL  = 4'b1000;
  localparam logic [3:0] O_WAIT = 4'b0000;
  localparam logic [3:0] O_MEM  = 4'b0100;
  localparam logic [3:0] O_RUN  = 4'b0111;

  assign w_outs = {pll_rst, mem_resetn, core_resetn, ready};

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .STAGE_GAP_CYCLES   (4)
  ) u_dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .mem_resetn  (mem_resetn),
    .core_resetn (core_resetn),
    .ready       (ready),
    .relock_count(relock_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Reset, then release on a falling edge; the next rising edge is edge 1.
  task automatic do_reset();
    pll_locked = 1'b0;
    relock_req = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    #1 rst_n = 1'b0;
    x.outs = O_PLL;
    x.cnt  = 8'd0;
    sbq.push_back(x);
    #1;
    x = sbq.pop_front();
    n_cmp++;
    if (w_outs !== x.outs || relock_count !== x.cnt) begin
      n_bad++;
      $display("FAIL reset: outs=%b cnt=%0d, required outs=%b cnt=%0d",
               w_outs, relock_count, x.outs, x.cnt);
    end
  endtask

  // Lock raised after edge 10: locked_s high after 12, STABLE from 13,
  // 8 STABLE cycles -> mem_resetn after 21, 4 gap cycles -> RUN after 25.
  task automatic test_clean_start();
    exp_t x;
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      if (e < 4)       x.outs = O_PLL;
      else if (e < 21) x.outs = O_WAIT;
      else if (e < 25) x.outs = O_MEM;
      else             x.outs = O_RUN;
      x.cnt = 8'd0;
      sbq.push_back(x);
    end
    for (int e = 0; e <= 30; e++) begin
      if (e > 0) begin
        @(posedge refclk);
        #1;
      end
      if (e == 10) pll_locked = 1'b1;
      x = sbq.pop_front();
      n_cmp++;
      if (w_outs !== x.outs || relock_count !== x.cnt) begin
        n_bad++;
        $display("FAIL clean_start e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e, w_outs, relock_count, x.outs, x.cnt);
      end
    end
  endtask

  // No lock: 4 cycles of pll_rst then 32 of WAIT_LOCK, period 36.
  task automatic test_timeout();
    exp_t x;
    do_reset();
    for (int e = 0; e <= 110; e++) begin
      x.outs = ((e % 36) < 4) ? O_PLL : O_WAIT;
      x.cnt  = 8'd0;
      sbq.push_back(x);
    end
    for (int e = 0; e <= 110; e++) begin
      if (e > 0) begin
        @(posedge refclk);
        #1;
      end
      x = sbq.pop_front();
      n_cmp++;
      if (w_outs !== x.outs || relock_count !== x.cnt) begin
        n_bad++;
        $display("FAIL timeout e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e, w_outs, relock_count, x.outs, x.cnt);
      end
    end
  endtask

  // Lock high after 10..14, low after 15, high from 16: locked_s drops for the
  // sample at edge 18, STABLE restarts at 19 -> mem after 27, RUN after 31.
  task automatic test_glitch();
    exp_t x;
    do_reset();
    for (int e = 0; e <= 35; e++) begin
      if (e < 4)       x.outs = O_PLL;
      else if (e < 27) x.outs = O_WAIT;
      else if (e < 31) x.outs = O_MEM;
      else             x.outs = O_RUN;
      x.cnt = 8'd0;
      sbq.push_back(x);
    end
    for (int e = 0; e <= 35; e++) begin
      if (e > 0) begin
        @(posedge refclk);
        #1;
      end
      if (e == 10) pll_locked = 1'b1;
      if (e == 15) pll_locked = 1'b0;
      if (e == 16) pll_locked = 1'b1;
      x = sbq.pop_front();
      n_cmp++;
      if (w_outs !== x.outs || relock_count !== x.cnt) begin
        n_bad++;
        $display("FAIL glitch e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e, w_outs, relock_count, x.outs, x.cnt);
      end
    end
  endtask

  // From RUN: lock low for one cycle after edge 0. RUN sees it at edge 3,
  // PLL_RESET 3..6, WAIT 7, STABLE 8..15, RELEASE_MEM 16..19, RUN at 20.
  task automatic test_lock_loss_repeat();
    exp_t x;
    int   prev;
    int   nxt;
    for (int i = 0; i < 300; i++) begin
      prev = (i < 255) ? i : 255;
      nxt  = (i + 1 < 255) ? i + 1 : 255;
      for (int e = 1; e <= 20; e++) begin
        if (e < 3)       x.outs = O_RUN;
        else if (e < 7)  x.outs = O_PLL;
        else if (e < 16) x.outs = O_WAIT;
        else if (e < 20) x.outs = O_MEM;
        else             x.outs = O_RUN;
        x.cnt = (e < 3) ? 8'(prev) : 8'(nxt);
        sbq.push_back(x);
      end
      pll_locked = 1'b0;
      for (int e = 1; e <= 20; e++) begin
        @(posedge refclk);
        #1;
        if (e == 1) pll_locked = 1'b1;
        x = sbq.pop_front();
        n_cmp++;
        if (w_outs !== x.outs || relock_count !== x.cnt) begin
          n_bad++;
          $display("FAIL lock_loss i=%0d e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                   i, e, w_outs, relock_count, x.outs, x.cnt);
        end
      end
    end
  endtask

  // Relock request from RUN, then request coincident with lock loss (plus a
  // request during PLL_RESET that must not stretch it), then reset mid-RELEASE_MEM.
  task automatic test_relock_req();
    exp_t x;
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      @(posedge refclk);
      #1;
      if (e == 10) pll_locked = 1'b1;
    end
    x.outs = O_RUN;
    x.cnt  = 8'd0;
    sbq.push_back(x);
    x = sbq.pop_front();
    n_cmp++;
    if (w_outs !== x.outs || relock_count !== x.cnt) begin
      n_bad++;
      $display("FAIL relock_setup: outs=%b cnt=%0d, required outs=%b cnt=%0d",
               w_outs, relock_count, x.outs, x.cnt);
    end

    // Request alone: PLL_RESET 1..4, WAIT 5, STABLE 6..13, mem 14..17, RUN 18.
    for (int e = 1; e <= 18; e++) begin
      if (e < 5)       x.outs = O_PLL;
      else if (e < 14) x.outs = O_WAIT;
      else if (e < 18) x.outs = O_MEM;
      else             x.outs = O_RUN;
      x.cnt = 8'd0;
      sbq.push_back(x);
    end
    relock_req = 1'b1;
    for (int e = 1; e <= 18; e++) begin
      @(posedge refclk);
      #1;
      if (e == 1) relock_req = 1'b0;
      x = sbq.pop_front();
      n_cmp++;
      if (w_outs !== x.outs || relock_count !== x.cnt) begin
        n_bad++;
        $display("FAIL relock_only e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e, w_outs, relock_count, x.outs, x.cnt);
      end
    end

    // Request and lock loss both seen at edge 3; second request seen at edge 5.
    for (int e = 1; e <= 20; e++) begin
      if (e < 3)       x.outs = O_RUN;
      else if (e < 7)  x.outs = O_PLL;
      else if (e < 16) x.outs = O_WAIT;
      else if (e < 20) x.outs = O_MEM;
      else             x.outs = O_RUN;
      x.cnt = (e < 3) ? 8'd0 : 8'd1;
      sbq.push_back(x);
    end
    pll_locked = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge refclk);
      #1;
      if (e == 1) pll_locked = 1'b1;
      if (e == 2) relock_req = 1'b1;
      if (e == 3) relock_req = 1'b0;
      if (e == 4) relock_req = 1'b1;
      if (e == 5) relock_req = 1'b0;
      x = sbq.pop_front();
      n_cmp++;
      if (w_outs !== x.outs || relock_count !== x.cnt) begin
        n_bad++;
        $display("FAIL relock_and_loss e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e, w_outs, relock_count, x.outs, x.cnt);
      end
    end

    // Into RELEASE_MEM again, then assert rst_n between edges.
    for (int e = 1; e <= 15; e++) begin
      if (e < 5)       x.outs = O_PLL;
      else if (e < 14) x.outs = O_WAIT;
      else             x.outs = O_MEM;
      x.cnt = 8'd1;
      sbq.push_back(x);
    end
    x.outs = O_PLL;
    x.cnt  = 8'd0;
    sbq.push_back(x);
    relock_req = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge refclk);
      #1;
      if (e == 1) relock_req = 1'b0;
      x = sbq.pop_front();
      n_cmp++;
      if (w_outs !== x.outs || relock_count !== x.cnt) begin
        n_bad++;
        $display("FAIL to_release e=%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e, w_outs, relock_count, x.outs, x.cnt);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    x = sbq.pop_front();
    n_cmp++;
    if (w_outs !== x.outs || relock_count !== x.cnt) begin
      n_bad++;
      $display("FAIL async_reset: outs=%b cnt=%0d, required outs=%b cnt=%0d",
               w_outs, relock_count, x.outs, x.cnt);
    end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_clean_start();
    test_timeout();
    test_glitch();
    test_lock_loss_repeat();
    test_relock_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
